press_classifier_1: RTL and testbench



---
 rtl/press_classifier_1_pkg.sv | 22 ++
 rtl/press_classifier_1_event_holder.sv | 58 +++++
 rtl/press_classifier_1.sv | 156 +++++++++++++++
 tb/tb_press_classifier_1.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/press_classifier_1_pkg.sv
// Shared definitions for the press classifier and its result holder.
// Event codes presented on result, and the classifier state encoding
// (also used by the testbench).
package press_classifier_1_pkg;

  typedef enum logic [1:0] {
    EV_NONE   = 2'd0,
    EV_SHORT  = 2'd1,
    EV_DOUBLE = 2'd2,
    EV_LONG   = 2'd3
  } event_e;

  typedef enum logic [2:0] {
    ST_ARM    = 3'd0,
    ST_IDLE   = 3'd1,
    ST_PRESS  = 3'd2,
    ST_HELD   = 3'd3,
    ST_GAP    = 3'd4,
    ST_SECOND = 3'd5
  } state_e;

endpackage

// File: rtl/press_classifier_1_event_holder.sv
// event_holder_1: holds one pending event code with a ready/ack handshake.
// A new event is accepted when nothing is pending or the pending one is
// being acknowledged in the same cycle; otherwise it is dropped and the
// sticky overrun flag is raised (cleared only by rst).
module event_holder_1
  import press_classifier_1_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       emit,
  input  logic [1:0] code,
  input  logic       result_ack,
  output logic [1:0] result,
  output logic       result_ready,
  output logic       overrun
);

  logic [1:0] result_q, result_d;
  logic       ready_q, ready_d;
  logic       overrun_q, overrun_d;
  logic       accept;

  // Decide acceptance of a new event and the handshake next-state.
  always_comb begin
    accept    = emit && (!ready_q || result_ack);
    result_d  = result_q;
    ready_d   = ready_q;
    overrun_d = overrun_q;
    if (accept) begin
      result_d = code;
      ready_d  = 1'b1;
    end else if (ready_q && result_ack) begin
      result_d = EV_NONE;
      ready_d  = 1'b0;
    end
    if (emit && !accept) begin
      overrun_d = 1'b1;
    end
  end

  // Holder registers, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q  <= EV_NONE;
      ready_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      result_q  <= result_d;
      ready_q   <= ready_d;
      overrun_q <= overrun_d;
    end
  end

  assign result       = result_q;
  assign result_ready = ready_q;
  assign overrun      = overrun_q;

endmodule

// File: rtl/press_classifier_1.sv
// press_classifier_1: classifies debounced button gestures into SHORT,
// DOUBLE or LONG events, handed to the consumer through event_holder_1.
// Optional macro PRESS_CLASSIFIER_REPEAT_EN: while the button stays held
// after a LONG, re-emit LONG every REPEAT_CYCLES cycles.
module press_classifier_1
  import press_classifier_1_pkg::*;
#(
  parameter int CW            = 24,
  parameter int LONG_CYCLES   = 8388608,
  parameter int GAP_CYCLES    = 4194304,
  parameter int REPEAT_CYCLES = 2097152
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       deb_in,
  input  logic       result_ack,
  output logic [1:0] result,
  output logic       result_ready,
  output logic       overrun
);

  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
`ifdef PRESS_CLASSIFIER_REPEAT_EN
  localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_CYCLES - 1);
`endif

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          emit;
  logic [1:0]    code;

  // State and cycle counter registers; reset lands in ARM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_ARM;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and counter update; the counter restarts on each state entry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_ARM: begin
        if (!deb_in) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (deb_in) begin
          state_d = ST_PRESS;
          cnt_d   = '0;
        end
      end
      ST_PRESS: begin
        if (!deb_in) begin
          state_d = ST_GAP;
          cnt_d   = '0;
        end else if (cnt_q == LONG_LAST) begin
          state_d = ST_HELD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_HELD: begin
        if (!deb_in) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
`ifdef PRESS_CLASSIFIER_REPEAT_EN
        else if (cnt_q == REPEAT_LAST) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
`endif
      end
      ST_GAP: begin
        if (deb_in) begin
          state_d = ST_SECOND;
          cnt_d   = '0;
        end else if (cnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_SECOND: begin
        if (!deb_in) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_ARM;
        cnt_d   = '0;
      end
    endcase
  end

  // Event decisions, raised in the cycle the deciding sample or match occurs.
  always_comb begin
    emit = 1'b0;
    code = EV_NONE;
    case (state_q)
      ST_PRESS: begin
        if (deb_in && (cnt_q == LONG_LAST)) begin
          emit = 1'b1;
          code = EV_LONG;
        end
      end
`ifdef PRESS_CLASSIFIER_REPEAT_EN
      ST_HELD: begin
        if (deb_in && (cnt_q == REPEAT_LAST)) begin
          emit = 1'b1;
          code = EV_LONG;
        end
      end
`endif
      ST_GAP: begin
        if (!deb_in && (cnt_q == GAP_LAST)) begin
          emit = 1'b1;
          code = EV_SHORT;
        end
      end
      ST_SECOND: begin
        if (!deb_in) begin
          emit = 1'b1;
          code = EV_DOUBLE;
        end
      end
      default: begin
        emit = 1'b0;
        code = EV_NONE;
      end
    endcase
  end

  event_holder_1 u_holder (
    .clk          (clk),
    .rst          (rst),
    .emit         (emit),
    .code         (code),
    .result_ack   (result_ack),
    .result       (result),
    .result_ready (result_ready),
    .overrun      (overrun)
  );

endmodule

// File: tb/tb_press_classifier_1.sv
// Testbench for press_classifier_1 with short timing constants
// (LONG 8, GAP 4, REPEAT 3). Inputs change on the falling edge and
// outputs are compared 1 time unit after the rising edge.
module tb_press_classifier_1;
  import press_classifier_1_pkg::*;

`ifdef PRESS_CLASSIFIER_REPEAT_EN
  localparam logic REP = 1'b1;
`else
  localparam logic REP = 1'b0;
`endif

  typedef struct {
    logic       rst;
    logic       deb;
    logic       ack;
    logic [1:0] res;
    logic       rdy;
    logic       ovr;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       deb_in;
  logic       result_ack;
  logic [1:0] result;
  logic       result_ready;
  logic       overrun;

  int checks = 0;
  int errors = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  press_classifier_1 #(
    .CW            (24),
    .LONG_CYCLES   (8),
    .GAP_CYCLES    (4),
    .REPEAT_CYCLES (3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .deb_in       (deb_in),
    .result_ack   (result_ack),
    .result       (result),
    .result_ready (result_ready),
    .overrun      (overrun)
  );

  // Queue n identical vectors.
  task automatic addRep(input int n, input logic r, input logic d, input logic a,
                        input logic [1:0] er, input logic erdy, input logic eovr);
    for (int i = 0; i < n; i++) begin
      tbl.push_back('{rst: r, deb: d, ack: a, res: er, rdy: erdy, ovr: eovr});
    end
  endtask

  // Drive inputs on the falling edge so they settle before the next rising edge.
  task automatic applyStimulus(input logic r, input logic d, input logic a);
    @(negedge clk);
    rst        = r;
    deb_in     = d;
    result_ack = a;
  endtask

  // Compare all outputs against the expected values.
  task automatic checkOutput(input string name, input logic [1:0] er,
                             input logic erdy, input logic eovr);
    checks++;
    if (result !== er || result_ready !== erdy || overrun !== eovr) begin
      errors++;
      $display("[TB] FAIL %s: got result=%0d ready=%0b overrun=%0b, expected result=%0d ready=%0b overrun=%0b",
               name, result, result_ready, overrun, er, erdy, eovr);
    end
  endtask

  // Apply every queued vector, check after its rising edge, then empty the queue.
  task automatic runTable(input string phase);
    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i].rst, tbl[i].deb, tbl[i].ack);
      @(posedge clk);
      #1;
      checkOutput($sformatf("%s[%0d]", phase, i), tbl[i].res, tbl[i].rdy, tbl[i].ovr);
    end
    tbl.delete();
  endtask

  initial begin
    rst        = 1'b1;
    deb_in     = 1'b1;
    result_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset", EV_NONE, 1'b0, 1'b0);

    // Button held through reset release: ARM must swallow it.
    addRep(20, 0, 1, 0, EV_NONE, 0, 0);
    addRep(3,  0, 0, 0, EV_NONE, 0, 0);
    // SHORT: 3 high, then the 5th low sample decides; ack clears.
    addRep(3,  0, 1, 0, EV_NONE, 0, 0);
    addRep(4,  0, 0, 0, EV_NONE, 0, 0);
    addRep(1,  0, 0, 0, EV_SHORT, 1, 0);
    addRep(1,  0, 0, 1, EV_NONE, 0, 0);
    addRep(1,  0, 0, 0, EV_NONE, 0, 0);
    // DOUBLE: high 3, low 2, high 2, then low.
    addRep(3,  0, 1, 0, EV_NONE, 0, 0);
    addRep(2,  0, 0, 0, EV_NONE, 0, 0);
    addRep(2,  0, 1, 0, EV_NONE, 0, 0);
    addRep(1,  0, 0, 0, EV_DOUBLE, 1, 0);
    addRep(1,  0, 0, 1, EV_NONE, 0, 0);
    addRep(1,  0, 0, 0, EV_NONE, 0, 0);
    // SHORT left pending, then DOUBLE completes with ack in the same cycle.
    addRep(3,  0, 1, 0, EV_NONE, 0, 0);
    addRep(4,  0, 0, 0, EV_NONE, 0, 0);
    addRep(1,  0, 0, 0, EV_SHORT, 1, 0);
    addRep(3,  0, 1, 0, EV_SHORT, 1, 0);
    addRep(2,  0, 0, 0, EV_SHORT, 1, 0);
    addRep(2,  0, 1, 0, EV_SHORT, 1, 0);
    addRep(1,  0, 0, 1, EV_DOUBLE, 1, 0);
    // SHORT completes while DOUBLE is pending: dropped, overrun set.
    addRep(3,  0, 1, 0, EV_DOUBLE, 1, 0);
    addRep(4,  0, 0, 0, EV_DOUBLE, 1, 0);
    addRep(1,  0, 0, 0, EV_DOUBLE, 1, 1);
    addRep(1,  0, 0, 1, EV_NONE, 0, 1);
    // Ack with nothing pending is ignored.
    addRep(1,  0, 0, 1, EV_NONE, 0, 1);
    runTable("seq1");

    // Pending SHORT, then rst asserted mid-GAP between clock edges.
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0);
    @(posedge clk);
    #1;
    checkOutput("rstGapPending", EV_SHORT, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0);
    for (int i = 0; i < 2; i++) applyStimulus(0, 0, 0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rstAsync", EV_NONE, 1'b0, 1'b0);
    applyStimulus(1, 0, 0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 0, 0);
      @(posedge clk);
      #1;
      checkOutput($sformatf("rstNoEvent[%0d]", i), EV_NONE, 1'b0, 1'b0);
    end

    // LONG: 12 high cycles with no ack, then release.
    addRep(8,  0, 1, 0, EV_NONE, 0, 0);
    addRep(3,  0, 1, 0, EV_LONG, 1, 0);
    addRep(1,  0, 1, 0, EV_LONG, 1, REP);
    addRep(1,  0, 0, 0, EV_LONG, 1, REP);
    addRep(1,  0, 0, 1, EV_NONE, 0, REP);
    addRep(2,  0, 0, 0, EV_NONE, 0, REP);
    runTable("long");

    $display("[TB] Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
